operand_bus_arbiter: RTL and testbench

Two-requester, round-robin arbiter sharing one 16-bit data path between two sources, e.g. register-file write-back and load unit. It drives the select of the existing 16-bit 2:1 mux, acknowledges the winning requester, and captures the chosen word into a one-entry output register with a valid/ready handshake toward the consumer. A hold limit bounds how long one requester can monopolise the path while the other waits.

---
 rtl/operand_bus_arbiter_pkg.sv | 13 +
 rtl/MUX_2to1.sv | 15 +
 rtl/operand_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_operand_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_bus_arbiter_pkg.sv
// Shared definitions for the operand bus arbiter: state encoding and default widths.
package operand_bus_arbiter_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int HOLD_W     = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } arb_state_e;

endpackage

// File: rtl/MUX_2to1.sv
// Plain 2:1 data mux; select=0 passes in0, select=1 passes in1.
module MUX_2to1
    import operand_bus_arbiter_pkg::*;
#(
    parameter int W = DATA_W_DEF
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic         select,
    output logic [W-1:0] out
);

    assign out = select ? in1 : in0;

endmodule

// File: rtl/operand_bus_arbiter.sv
// Round-robin arbiter for two requesters sharing one data path, with a hold
// limit on consecutive grants and a one-entry valid/ready output register.
module operand_bus_arbiter
    import operand_bus_arbiter_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              ack0,
    output logic              ack1,
    output logic              sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic              cap;
    logic [HOLD_W:0]   hold_inc;
    logic              hold_limit;
    logic [DATA_W-1:0] mux_out;

    // The output register can take a new word if empty or being drained now.
    assign cap        = ~out_valid_q | out_ready;
    assign hold_inc   = {1'b0, hold_cnt_q} + {{HOLD_W{1'b0}}, 1'b1};
    // ">=" rather than "==" so a saturated counter still yields to a late requester.
    assign hold_limit = (hold_inc >= {1'b0, MAX_HOLD_C});

    MUX_2to1 #(
        .W (DATA_W)
    ) u_mux (
        .in0    (data0),
        .in1    (data1),
        .select (sel),
        .out    (mux_out)
    );

    // Arbitration FSM: next state, owner history, hold counter, acks and select.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        ack0       = 1'b0;
        ack1       = 1'b0;
        sel        = last_q;
        case (state_q)
            IDLE: begin
                sel = last_q;
                if (req0 && req1) begin
                    state_d    = last_q ? GRANT0 : GRANT1;
                    hold_cnt_d = '0;
                end else if (req0) begin
                    state_d    = GRANT0;
                    hold_cnt_d = '0;
                end else if (req1) begin
                    state_d    = GRANT1;
                    hold_cnt_d = '0;
                end
            end
            GRANT0: begin
                sel  = 1'b0;
                ack0 = req0 & cap;
                if (!req0) begin
                    state_d    = req1 ? GRANT1 : IDLE;
                    hold_cnt_d = '0;
                end else if (ack0) begin
                    last_d     = 1'b0;
                    hold_cnt_d = hold_limit ? MAX_HOLD_C : hold_inc[HOLD_W-1:0];
                    if (hold_limit && req1) begin
                        state_d    = GRANT1;
                        hold_cnt_d = '0;
                    end
                end
            end
            GRANT1: begin
                sel  = 1'b1;
                ack1 = req1 & cap;
                if (!req1) begin
                    state_d    = req0 ? GRANT0 : IDLE;
                    hold_cnt_d = '0;
                end else if (ack1) begin
                    last_d     = 1'b1;
                    hold_cnt_d = hold_limit ? MAX_HOLD_C : hold_inc[HOLD_W-1:0];
                    if (hold_limit && req0) begin
                        state_d    = GRANT0;
                        hold_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register: load the muxed word on any ack, empty it when drained.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (ack0 || ack1) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_out;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset drops any pending word and favours requester 0 next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            hold_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_operand_bus_arbiter.sv
// Self-checking bench for operand_bus_arbiter: vector table plus hand sequences,
// with a scoreboard matching acked words against words leaving the output register.
module tb_operand_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1;
    logic [15:0] data0, data1;
    logic        ack0, ack1;
    logic        sel;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;

    int n_checks;
    int n_fail;

    logic [15:0] sb[$];

    typedef struct {
        logic        rst;
        logic        r0;
        logic        r1;
        logic        rdy;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        ea0;
        logic        ea1;
        logic        esel;
        logic        evalid;
    } vec_t;

    vec_t vecs[$];

    operand_bus_arbiter #(
        .DATA_W   (16),
        .MAX_HOLD (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .data0     (data0),
        .data1     (data1),
        .ack0      (ack0),
        .ack1      (ack1),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Wait for the sampling edge and run the scoreboard: drain first, then record new acks.
    task automatic sample_edge();
        logic [15:0] exp_w;
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got out_data %h with no word expected", out_data);
            end else begin
                exp_w = sb.pop_front();
                chk("sb_out_data", 32'(out_data), 32'(exp_w));
            end
        end
        if (rst_n && ack0) sb.push_back(data0);
        if (rst_n && ack1) sb.push_back(data1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req0      = 1'b0;
        req1      = 1'b0;
        data0     = '0;
        data1     = '0;
        out_ready = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic add(input logic rst, input logic r0, input logic r1, input logic rdy,
                       input logic [15:0] d0, input logic [15:0] d1,
                       input logic ea0, input logic ea1, input logic esel, input logic evalid);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.rdy = rdy; v.d0 = d0; v.d1 = d1;
        v.ea0 = ea0; v.ea1 = ea1; v.esel = esel; v.evalid = evalid;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        n_checks = 0;
        n_fail   = 0;

        //    rst  r0   r1   rdy  d0        d1        ack0 ack1 sel  valid
        // Single request latency from idle.
        add(1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        // Both requesting after reset: groups of four, no idle cycle between.
        add(1'b1, 1'b1, 1'b1, 1'b1, 16'hA000, 16'hB000, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 16'hA000, 16'hB000, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 16'hA001, 16'hB000, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b1, 16'hA002, 16'hB000, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b1, 16'hA003, 16'hB000, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b1, 16'hA004, 16'hB000, 1'b0, 1'b1, 1'b1, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b1, 16'hA004, 16'hB001, 1'b0, 1'b1, 1'b1, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b1, 16'hA004, 16'hB002, 1'b0, 1'b1, 1'b1, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b1, 16'hA004, 16'hB003, 1'b0, 1'b1, 1'b1, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b1, 16'hA004, 16'hB004, 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset values, checked while reset is held and just after release.
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0; out_ready = 1'b1;
        @(negedge clk);
        chk("rst_sel", 32'(sel), 32'h1);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_acks", 32'({ack0, ack1}), 32'h0);

        // Table-driven vectors.
        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            req0 = vecs[i].r0; req1 = vecs[i].r1; out_ready = vecs[i].rdy;
            data0 = vecs[i].d0; data1 = vecs[i].d1;
            sample_edge();
            chk($sformatf("vec%0d_ack0", i), 32'(ack0), 32'(vecs[i].ea0));
            chk($sformatf("vec%0d_ack1", i), 32'(ack1), 32'(vecs[i].ea1));
            chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].esel));
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].evalid));
            $display("vec %0d: req=%b%b rdy=%b ack=%b%b sel=%b valid=%b data=%h",
                     i, req0, req1, out_ready, ack0, ack1, sel, out_valid, out_data);
            next_cycle();
        end

        // Backpressure: five stalled cycles, then ack on the cycle ready returns.
        do_reset();
        req1 = 1'b1; data1 = 16'hC001;
        sample_edge(); next_cycle();
        sample_edge();
        chk("bp_first_ack1", 32'(ack1), 32'h1);
        next_cycle();
        out_ready = 1'b0; data1 = 16'hC002;
        for (int i = 0; i < 5; i++) begin
            sample_edge();
            chk("bp_stall_ack1", 32'(ack1), 32'h0);
            chk("bp_stall_valid", 32'(out_valid), 32'h1);
            chk("bp_stall_data", 32'(out_data), 32'hC001);
            $display("bp stall %0d: ack1=%b valid=%b data=%h", i, ack1, out_valid, out_data);
            next_cycle();
        end
        out_ready = 1'b1;
        sample_edge();
        chk("bp_release_ack1", 32'(ack1), 32'h1);
        next_cycle();
        req1 = 1'b0;
        sample_edge();
        chk("bp_new_valid", 32'(out_valid), 32'h1);
        chk("bp_new_data", 32'(out_data), 32'hC002);
        $display("bp release: valid=%b data=%h", out_valid, out_data);
        next_cycle();

        // Sole requester: ten back-to-back transfers, grant never leaves requester 0.
        do_reset();
        req0 = 1'b1; data0 = 16'hD000;
        sample_edge();
        chk("hold_idle_ack0", 32'(ack0), 32'h0);
        next_cycle();
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            data0 = 16'hD000 + 16'(i);
            sample_edge();
            if (ack0) acks++;
            chk("hold_ack1", 32'(ack1), 32'h0);
            chk("hold_sel", 32'(sel), 32'h0);
            $display("hold xfer %0d: ack0=%b sel=%b data0=%h", i, ack0, sel, data0);
            next_cycle();
        end
        chk("hold_ack_count", 32'(acks), 32'd10);
        req0 = 1'b0;
        sample_edge(); next_cycle();

        // Owner drops req0 as req1 rises: direct switch, ack1 on the next cycle.
        do_reset();
        req0 = 1'b1; data0 = 16'hE000;
        sample_edge(); next_cycle();
        sample_edge();
        chk("sw_first_ack0", 32'(ack0), 32'h1);
        next_cycle();
        req0 = 1'b0; req1 = 1'b1; data1 = 16'hE100;
        sample_edge();
        chk("sw_drop_acks", 32'({ack0, ack1}), 32'h0);
        next_cycle();
        sample_edge();
        chk("sw_ack1", 32'(ack1), 32'h1);
        chk("sw_sel", 32'(sel), 32'h1);
        $display("switch: ack1=%b sel=%b", ack1, sel);
        next_cycle();
        req1 = 1'b0;
        sample_edge(); next_cycle();

        // Asynchronous reset with a word pending, then requester 0 wins first.
        do_reset();
        req1 = 1'b1; data1 = 16'hBEEF;
        sample_edge(); next_cycle();
        sample_edge(); next_cycle();
        req1 = 1'b0; out_ready = 1'b0;
        sample_edge();
        chk("mid_pre_valid", 32'(out_valid), 32'h1);
        chk("mid_pre_data", 32'(out_data), 32'hBEEF);
        next_cycle();
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_data", 32'(out_data), 32'h0);
        chk("mid_rst_sel", 32'(sel), 32'h1);
        $display("mid reset: valid=%b data=%h sel=%b", out_valid, out_data, sel);
        next_cycle();
        rst_n = 1'b1; out_ready = 1'b1;
        req0 = 1'b1; req1 = 1'b1; data0 = 16'hF000; data1 = 16'hF001;
        sample_edge(); next_cycle();
        sample_edge();
        chk("post_rst_ack0", 32'(ack0), 32'h1);
        chk("post_rst_ack1", 32'(ack1), 32'h0);
        $display("post reset grant: ack0=%b ack1=%b", ack0, ack1);
        next_cycle();
        req0 = 1'b0; req1 = 1'b0;
        sample_edge(); next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
